// File: rtl/count_seq_pkg.sv
// Shared encodings for the count sequencer: FSM states, terminal counter
// values and the direction-dependent load/terminal helpers.
package count_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] TERM_DOWN = 4'h0;
   localparam logic [3:0] TERM_UP   = 4'hF;

   // Value at which a run in the given direction has finished.
   function automatic logic [3:0] term_val(input logic up);
      return up ? TERM_UP : TERM_DOWN;
   endfunction

   // A run starts from the opposite end of the range it counts toward.
   function automatic logic [3:0] load_val(input logic up);
      return up ? TERM_DOWN : TERM_UP;
   endfunction

endpackage

// File: rtl/count_seq_if.sv
// Control/status bundle between the count sequencer and the external
// 4-bit counter it drives.
interface count_seq_if;
   logic       cs_start;
   logic       cs_stop;
   logic       cs_pause;
   logic       cs_dir;
   logic [3:0] cs_count;
   logic       cs_tick;
   logic       cs_up;
   logic       cs_ld;
   logic [3:0] cs_ld_val;
   logic       cs_done;
   logic [1:0] cs_state;

   modport slave (
      input  cs_start, cs_stop, cs_pause, cs_dir, cs_count,
      output cs_tick, cs_up, cs_ld, cs_ld_val, cs_done, cs_state
   );

   modport master (
      output cs_start, cs_stop, cs_pause, cs_dir, cs_count,
      input  cs_tick, cs_up, cs_ld, cs_ld_val, cs_done, cs_state
   );
endinterface

// File: rtl/count_seq_tick_gen.sv
// Prescaler: counts enabled cycles modulo DIV and emits a registered
// one-cycle tick in the cycle after each wrap.
module tick_gen #(
   parameter int unsigned DIV = 100_000_000,
   parameter int          CW  = $clog2(DIV)
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clr,
   output logic tick
);

   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (run) begin
            if (cnt == LAST) begin
               cnt  <= '0;
               tick <= 1'b1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/count_seq.sv
// Run/pause/done sequencer for an external 4-bit up/down counter: latches
// direction on start, loads the counter, paces it with a prescaled tick.
module count_seq
   import count_seq_pkg::*;
#(
   parameter int unsigned DIV = 100_000_000,
   parameter int          CW  = $clog2(DIV)
) (
   input  logic        cs_clk,
   input  logic        cs_rst,
   count_seq_if.slave  bus
);

   state_t state, state_nxt;
   logic   up, up_nxt;
   logic   ld, ld_nxt;
   logic   clr;
   logic   run;
   logic   term;
   logic   tick;

   // The load cycle is excluded: the counter still holds its stale value.
   assign term = (state == ST_RUN) && !ld && (bus.cs_count == term_val(up));

   always_comb begin
      state_nxt = state;
      up_nxt    = up;
      ld_nxt    = 1'b0;
      clr       = 1'b0;
      if (bus.cs_stop) begin
         state_nxt = ST_IDLE;
         clr       = 1'b1;
      end else if (bus.cs_start) begin
         state_nxt = ST_RUN;
         up_nxt    = bus.cs_dir;
         ld_nxt    = 1'b1;
         clr       = 1'b1;
      end else begin
         case (state)
            ST_RUN: begin
               if (bus.cs_pause)
                  state_nxt = ST_PAUSE;
               else if (term)
                  state_nxt = ST_DONE;
            end
            ST_PAUSE: begin
               if (bus.cs_pause)
                  state_nxt = ST_RUN;
            end
            default: ;
         endcase
      end
   end

   // Only cycles that stay in RUN advance the prescaler, so a registered
   // tick always lands in a RUN cycle and is never lost on a pause.
   assign run = (state == ST_RUN) && (state_nxt == ST_RUN) && !clr;

   always_ff @(posedge cs_clk or posedge cs_rst) begin
      if (cs_rst) begin
         state <= ST_IDLE;
         up    <= 1'b0;
         ld    <= 1'b0;
      end else begin
         state <= state_nxt;
         up    <= up_nxt;
         ld    <= ld_nxt;
      end
   end

   tick_gen #(
      .DIV (DIV),
      .CW  (CW)
   ) u_tick_gen (
      .clk  (cs_clk),
      .rst  (cs_rst),
      .run  (run),
      .clr  (clr),
      .tick (tick)
   );

   assign bus.cs_tick   = tick;
   assign bus.cs_up     = up;
   assign bus.cs_ld     = ld;
   assign bus.cs_ld_val = load_val(up);
   assign bus.cs_done   = (state == ST_DONE);
   assign bus.cs_state  = state;

endmodule
